spi_mstr_param: RTL and testbench

Parametrised SPI master, the successor to the fixed 16-bit master used by the inertial sensor and A2D interfaces.
- Generalises word width, SCLK divide ratio and number of slave selects.
- Adds a per-transaction bit length, slave-select choice and a busy output.
- Sits between the sensor/A2D control FSMs and the off-chip SPI pins. Always mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO sampled on SCLK rise.

---
 rtl/spi_mstr_param_if.sv | 24 ++
 rtl/spi_mstr_param.sv | 149 ++++++++++++++
 tb/tb_spi_mstr_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mstr_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_mstr_param_if : control-side bus of the parametrised SPI master |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface spi_mstr_param_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_SS = 2
);
   localparam int LEN_W = $clog2(WIDTH + 1);
   localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

   logic             wrt;
   logic [WIDTH-1:0] cmd;
   logic [LEN_W-1:0] len;
   logic [SS_W-1:0]  ss_sel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rd_data;

   modport master (output wrt, cmd, len, ss_sel, input  busy, done, rd_data);
   modport slave  (input  wrt, cmd, len, ss_sel, output busy, done, rd_data);
endinterface
`default_nettype wire

// File: rtl/spi_mstr_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_mstr_param : mode-3 SPI master, variable length and slave sel   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_mstr_param #(
   parameter int WIDTH    = 16,
   parameter int DIV_BITS = 5,
   parameter int NUM_SS   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_mstr_param_if.slave    bus,
   input  logic               MISO,
   output logic               SCLK,
   output logic               MOSI,
   output logic [NUM_SS-1:0]  SS_n
);
   localparam int LEN_W = $clog2(WIDTH + 1);

   localparam logic [DIV_BITS-1:0] c_preset =
      DIV_BITS'((1 << (DIV_BITS - 1)) + (1 << (DIV_BITS - 2)) - 1);
   localparam logic [DIV_BITS-1:0] c_sample = DIV_BITS'((1 << (DIV_BITS - 1)) - 1);
   localparam logic [DIV_BITS-1:0] c_shift  = '1;
   localparam logic [LEN_W-1:0]    c_width  = LEN_W'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_SAMPLE_WAIT = 2'd1,
      S_SHIFT_WAIT  = 2'd2,
      S_FINAL       = 2'd3
   } state_t;

   state_t              state_q,  state_d;
   logic [DIV_BITS-1:0] div_q,    div_d;
   logic [WIDTH-1:0]    shreg_q,  shreg_d;
   logic [WIDTH-1:0]    mask_q,   mask_d;
   logic [LEN_W-1:0]    len_q,    len_d;
   logic [LEN_W-1:0]    cnt_q,    cnt_d;
   logic                miso_q,   miso_d;
   logic [NUM_SS-1:0]   ss_n_q,   ss_n_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;

   logic [LEN_W-1:0]    w_len_eff;

   always_comb begin
      w_len_eff = (bus.len == '0 || bus.len > c_width) ? c_width : bus.len;

      state_d = state_q;
      div_d   = div_q;
      shreg_d = shreg_q;
      mask_d  = mask_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      miso_d  = miso_q;
      ss_n_d  = ss_n_q;
      busy_d  = busy_q;
      done_d  = done_q;

      case (state_q)
         S_IDLE: begin
            // Holding div at the preset gives the front porch before the first fall.
            div_d = c_preset;
            if (bus.wrt) begin
               len_d   = w_len_eff;
               shreg_d = bus.cmd << (c_width - w_len_eff);
               for (int i = 0; i < WIDTH; i++) begin
                  mask_d[i] = (i < int'(w_len_eff));
               end
               for (int i = 0; i < NUM_SS; i++) begin
                  ss_n_d[i] = (int'(bus.ss_sel) != i);
               end
               cnt_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SAMPLE_WAIT;
            end
         end

         S_SAMPLE_WAIT: begin
            div_d = div_q + 1'b1;
            if (div_q == c_sample) begin
               miso_d  = MISO;
               state_d = (cnt_q == len_q - 1'b1) ? S_FINAL : S_SHIFT_WAIT;
            end
         end

         S_SHIFT_WAIT: begin
            div_d = div_q + 1'b1;
            if (div_q == c_shift) begin
               shreg_d = {shreg_q[WIDTH-2:0], miso_q};
               cnt_d   = cnt_q + 1'b1;
               state_d = S_SAMPLE_WAIT;
            end
         end

         S_FINAL: begin
            div_d = div_q + 1'b1;
            if (div_q == c_shift) begin
               // Re-presetting instead of wrapping keeps SCLK high: no trailing fall.
               shreg_d = {shreg_q[WIDTH-2:0], miso_q};
               div_d   = c_preset;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ss_n_d  = '1;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= c_preset;
         shreg_q <= '0;
         mask_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b0;
         ss_n_q  <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         shreg_q <= shreg_d;
         mask_q  <= mask_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         miso_q  <= miso_d;
         ss_n_q  <= ss_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign SCLK        = div_q[DIV_BITS-1];
   assign MOSI        = shreg_q[WIDTH-1];
   assign SS_n        = ss_n_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_data = shreg_q & mask_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mstr_param.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_mstr_param: randomized scoreboard bench for the parametrised SPI master,
// a default build with a slave model and a small build with MOSI looped to MISO.
module tb_spi_mstr_param;
   localparam int W   = 16;
   localparam int D   = 5;
   localparam int N   = 2;
   localparam int LW  = $clog2(W + 1);
   localparam int SW  = (N > 1) ? $clog2(N) : 1;
   localparam int W2  = 8;
   localparam int D2  = 3;
   localparam int N2  = 3;
   localparam int LW2 = $clog2(W2 + 1);
   localparam int SW2 = (N2 > 1) ? $clog2(N2) : 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_mstr_param_if #(.WIDTH(W), .NUM_SS(N)) bus ();
   logic          MISO = 1'b0;
   logic          SCLK, MOSI;
   logic [N-1:0]  SS_n;

   spi_mstr_param #(.WIDTH(W), .DIV_BITS(D), .NUM_SS(N)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n));

   spi_mstr_param_if #(.WIDTH(W2), .NUM_SS(N2)) bus2 ();
   logic          SCLK2, MOSI2;
   logic [N2-1:0] SS_n2;

   spi_mstr_param #(.WIDTH(W2), .DIV_BITS(D2), .NUM_SS(N2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2),
      .MISO(MOSI2), .SCLK(SCLK2), .MOSI(MOSI2), .SS_n(SS_n2));

   typedef struct {
      logic [31:0] rd;
      logic [31:0] mosi;
      int          len;
      logic [7:0]  ss;
      longint      done_cyc;
      int          fall_base;
      int          rise_base;
   } exp_t;

   exp_t   sb[$];
   exp_t   sb2[$];
   int     n_chk  = 0;
   int     n_pass = 0;
   longint cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   function automatic int eff_len(input int l, input int w);
      return (l == 0 || l > w) ? w : l;
   endfunction

   function automatic logic [31:0] lowmask(input int l);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) if (i < l) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [7:0] ss_pat(input int sel, input int n);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < n; i++) s[i] = (i != sel);
      return s;
   endfunction

   function automatic longint latency(input int l, input int d);
      return longint'((1 << (d - 2)) + 1 + l * (1 << d));
   endfunction

   // ---------------- slave model (default build) ----------------
   logic [31:0] act_sw   = '0;
   int          act_len  = 0;
   int          act_base = 0;
   int          fall_cnt = 0;
   int          rise_cnt = 0;
   int          slv_k    = 0;
   logic [31:0] mosi_cap = '0;

   always @(negedge SCLK) begin
      fall_cnt = fall_cnt + 1;
      slv_k    = fall_cnt - act_base;
      if (slv_k >= 1 && slv_k <= act_len) MISO = act_sw[act_len - slv_k];
   end

   always @(posedge SCLK) begin
      rise_cnt = rise_cnt + 1;
      mosi_cap = {mosi_cap[30:0], MOSI};
   end

   // ---------------- monitor ----------------
   bit         busy_p, done_p, busy2_p, done2_p;
   logic [7:0] ss_seen, ss_seen2;
   exp_t       me, me2;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_p = 1'b0; done_p = 1'b0; busy2_p = 1'b0; done2_p = 1'b0;
      end else begin
         if (bus.busy && !busy_p) begin
            ss_seen = 8'(SS_n);
            chk("done_low_at_accept", 64'(bus.done), 64'(0));
         end
         if (bus.done && !done_p) begin
            if (sb.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
            else begin
               me = sb.pop_front();
               chk("rd_data",     64'(bus.rd_data), 64'(me.rd));
               chk("done_cycle",  64'(cyc), 64'(me.done_cyc));
               chk("mosi_bits",   64'(mosi_cap & lowmask(me.len)), 64'(me.mosi));
               chk("sclk_falls",  64'(fall_cnt - me.fall_base), 64'(me.len));
               chk("sclk_rises",  64'(rise_cnt - me.rise_base), 64'(me.len));
               chk("ss_during",   64'(ss_seen), 64'(me.ss));
               chk("ss_after",    64'(SS_n), 64'({N{1'b1}}));
               chk("busy_after",  64'(bus.busy), 64'(0));
               chk("sclk_idle",   64'(SCLK), 64'(1));
            end
         end
         if (bus2.busy && !busy2_p) ss_seen2 = 8'(SS_n2);
         if (bus2.done && !done2_p) begin
            if (sb2.size() == 0) chk("unexpected_done2", 64'(1), 64'(0));
            else begin
               me2 = sb2.pop_front();
               chk("rd_data2",    64'(bus2.rd_data), 64'(me2.rd));
               chk("done_cycle2", 64'(cyc), 64'(me2.done_cyc));
               chk("ss_during2",  64'(ss_seen2), 64'(me2.ss));
               chk("ss_after2",   64'(SS_n2), 64'({N2{1'b1}}));
            end
         end
         busy_p  = bus.busy;  done_p  = bus.done;
         busy2_p = bus2.busy; done2_p = bus2.done;
      end
   end

   // ---------------- drivers ----------------
   task automatic issue(input logic [W-1:0] c, input int l, input int sel,
                        input logic [W-1:0] sw, input bit hold, input bit pulses);
      int   g;
      int   le;
      exp_t e;
      g = 0;
      while (bus.busy !== 1'b0 && g < 3000) begin @(posedge clk); #1; g++; end
      if (g >= 3000) begin chk("idle_timeout", 64'(1), 64'(0)); return; end
      bus.cmd    = c;
      bus.len    = LW'(l);
      bus.ss_sel = SW'(sel);
      bus.wrt    = 1'b1;
      @(posedge clk); #1;
      chk("accepted", 64'(bus.busy), 64'(1));
      le          = eff_len(int'(bus.len), W);
      act_sw      = 32'(sw);
      act_len     = le;
      act_base    = fall_cnt;
      e.rd        = 32'(sw) & lowmask(le);
      e.mosi      = 32'(c) & lowmask(le);
      e.len       = le;
      e.ss        = ss_pat(int'(bus.ss_sel), N);
      e.done_cyc  = cyc + latency(le, D);
      e.fall_base = fall_cnt;
      e.rise_base = rise_cnt;
      sb.push_back(e);
      if (!hold) bus.wrt = 1'b0;
      if (pulses) begin
         repeat (3) begin
            @(posedge clk); #1;
            bus.wrt = 1'b1; bus.cmd = W'($urandom); bus.len = LW'($urandom);
            @(posedge clk); #1;
            bus.wrt = 1'b0;
         end
      end
   endtask

   task automatic issue2(input logic [W2-1:0] c, input int l, input int sel);
      int   g;
      int   le;
      exp_t e;
      g = 0;
      while (bus2.busy !== 1'b0 && g < 3000) begin @(posedge clk); #1; g++; end
      if (g >= 3000) begin chk("idle_timeout2", 64'(1), 64'(0)); return; end
      bus2.cmd    = c;
      bus2.len    = LW2'(l);
      bus2.ss_sel = SW2'(sel);
      bus2.wrt    = 1'b1;
      @(posedge clk); #1;
      chk("accepted2", 64'(bus2.busy), 64'(1));
      le         = eff_len(int'(bus2.len), W2);
      e.rd       = 32'(c) & lowmask(le);
      e.mosi     = '0;
      e.len      = le;
      e.ss       = ss_pat(int'(bus2.ss_sel), N2);
      e.done_cyc = cyc + latency(le, D2);
      e.fall_base = 0;
      e.rise_base = 0;
      sb2.push_back(e);
      bus2.wrt = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g;
      int fb;
      bus.wrt  = 1'b0; bus.cmd  = '0; bus.len  = '0; bus.ss_sel  = '0;
      bus2.wrt = 1'b0; bus2.cmd = '0; bus2.len = '0; bus2.ss_sel = '0;
      #23;
      chk("rst_ss_n",  64'(SS_n), 64'({N{1'b1}}));
      chk("rst_sclk",  64'(SCLK), 64'(1));
      chk("rst_busy",  64'(bus.busy), 64'(0));
      chk("rst_done",  64'(bus.done), 64'(0));
      chk("rst_ss_n2", 64'(SS_n2), 64'({N2{1'b1}}));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      issue(16'hA5C3, 16, 1, 16'h3C5A, 1'b0, 1'b0);
      issue(16'h00F0, 8,  0, 16'h0096, 1'b0, 1'b0);
      issue(W'($urandom), 0, 1, W'($urandom), 1'b0, 1'b0);
      issue(16'h0001, 1,  0, 16'h0001, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++)
         issue(W'($urandom), $urandom_range(1, 16), $urandom_range(0, 1), W'($urandom), 1'b1, 1'b0);
      issue(W'($urandom), $urandom_range(1, 16), $urandom_range(0, 1), W'($urandom), 1'b0, 1'b0);

      for (int i = 0; i < 2; i++)
         issue(W'($urandom), $urandom_range(4, 16), $urandom_range(0, 1), W'($urandom), 1'b0, 1'b1);

      // asynchronous reset in the middle of a transfer
      issue(16'h1234, 16, 0, 16'hBEEF, 1'b0, 1'b0);
      fb = fall_cnt;
      g  = 0;
      while (fall_cnt - fb < 7 && g < 2000) begin @(posedge clk); #1; g++; end
      chk("reach_bit7", 64'(fall_cnt - fb >= 7), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ss_n", 64'(SS_n), 64'({N{1'b1}}));
      chk("midrst_sclk", 64'(SCLK), 64'(1));
      chk("midrst_done", 64'(bus.done), 64'(0));
      chk("midrst_busy", 64'(bus.busy), 64'(0));
      sb.delete();
      act_len = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'hC0DE, 16, 1, 16'h5A5A, 1'b0, 1'b0);

      // small build: fast divider, three selects, one out-of-range select
      issue2(8'hA7, 8, 2);
      issue2(8'h5C, 8, 3);
      issue2(W2'($urandom), 3, 1);
      issue2(W2'($urandom), 0, 0);

      for (int i = 0; i < 10; i++)
         issue(W'($urandom), $urandom_range(0, 31), $urandom_range(0, 1), W'($urandom), 1'b0, 1'b0);

      g = 0;
      while ((sb.size() != 0 || sb2.size() != 0) && g < 3000) begin @(posedge clk); #1; g++; end
      chk("drain", 64'(sb.size() + sb2.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
